// File: rtl/fll_cfg_apb_if.sv
// APB3 slave bridging SoC register accesses onto the FLL 4-phase cfg_req/cfg_ack port.
// Each handshake phase is bounded by a timeout so a dead FLL fails the APB access instead of hanging it.
module fll_cfg_apb_if #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [11:0] paddr_i,
  input  logic [31:0] pwdata_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o,
  output logic        cfg_req_o,
  output logic        cfg_wrn_o,
  output logic [1:0]  cfg_add_o,
  output logic [31:0] cfg_data_o,
  input  logic        cfg_ack_i,
  input  logic [31:0] cfg_r_data_i,
  output logic        timeout_o
);

  typedef enum logic [1:0] {IDLE, REQ, REL, RESP} state_e;

  localparam logic [15:0] CntLast = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic        ack_meta_q, ack_sync_q;
  logic [15:0] cnt_q;
  logic        err_q, timeout_q;
  logic [31:0] rdata_q, prdata_q;
  logic        pready_q, pslverr_q;
  logic        req_q, wrn_q;
  logic [1:0]  add_q;
  logic [31:0] data_q;

  logic        setup_d, addr_fll_d, addr_status_d, cnt_last_d;
  logic [31:0] status_d;

  assign setup_d       = psel_i && !penable_i;
  assign addr_fll_d    = (paddr_i[11:4] == 8'h00);
  assign addr_status_d = (paddr_i == 12'h010);
  assign cnt_last_d    = (cnt_q == CntLast);
  assign status_d      = {30'd0, ack_sync_q, timeout_q};

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      ack_meta_q <= 1'b0;
      ack_sync_q <= 1'b0;
      cnt_q      <= 16'd0;
      err_q      <= 1'b0;
      timeout_q  <= 1'b0;
      rdata_q    <= 32'd0;
      prdata_q   <= 32'd0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      req_q      <= 1'b0;
      wrn_q      <= 1'b0;
      add_q      <= 2'd0;
      data_q     <= 32'd0;
    end else begin
      ack_meta_q <= cfg_ack_i;
      ack_sync_q <= ack_meta_q;
      cnt_q      <= cnt_q + 16'd1;
      case (state_q)
        IDLE: begin
          cnt_q <= 16'd0;
          if (setup_d) begin
            if (addr_fll_d) begin
              state_q <= REQ;
              req_q   <= 1'b1;
              wrn_q   <= pwrite_i;
              add_q   <= paddr_i[3:2];
              data_q  <= pwdata_i;
              rdata_q <= 32'd0;
            end else begin
              // STATUS and illegal addresses answer locally without touching the FLL
              state_q   <= RESP;
              pready_q  <= 1'b1;
              pslverr_q <= !addr_status_d;
              prdata_q  <= (addr_status_d && !pwrite_i) ? status_d : 32'd0;
              if (addr_status_d && pwrite_i && pwdata_i[0]) timeout_q <= 1'b0;
            end
          end
        end
        REQ: begin
          if (ack_sync_q) begin
            if (!wrn_q) rdata_q <= cfg_r_data_i;
            state_q <= REL;
            req_q   <= 1'b0;
            cnt_q   <= 16'd0;
          end else if (cnt_last_d) begin
            err_q     <= 1'b1;
            timeout_q <= 1'b1;
            state_q   <= REL;
            req_q     <= 1'b0;
            cnt_q     <= 16'd0;
          end
        end
        REL: begin
          if (!ack_sync_q || cnt_last_d) begin
            state_q   <= RESP;
            cnt_q     <= 16'd0;
            pready_q  <= 1'b1;
            pslverr_q <= err_q || ack_sync_q;
            prdata_q  <= wrn_q ? 32'd0 : rdata_q;
            if (ack_sync_q) begin
              err_q     <= 1'b1;
              timeout_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          cnt_q     <= 16'd0;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= 32'd0;
          err_q     <= 1'b0;
        end
      endcase
    end
  end

  assign prdata_o   = prdata_q;
  assign pready_o   = pready_q;
  assign pslverr_o  = pslverr_q;
  assign cfg_req_o  = req_q;
  assign cfg_wrn_o  = wrn_q;
  assign cfg_add_o  = add_q;
  assign cfg_data_o = data_q;
  assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_fll_cfg_apb_if.sv
// Directed bench: dut_a (TIMEOUT_CYCLES=256) for ideal/slow FLL models, dut_b (16) for timeout paths.
module tb_fll_cfg_apb_if;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        psel_a = 0, psel_b = 0, penable = 0, pwrite = 0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;

  logic [31:0] prdata_a, prdata_b, data_a, data_b, rdat_a, rdat_b;
  logic        pready_a, pready_b, slverr_a, slverr_b;
  logic        req_a, req_b, wrn_a, wrn_b, ack_a, ack_b, tmo_a, tmo_b;
  logic [1:0]  add_a, add_b;

  int mode_a = 0, mode_b = 2;  // 0 ideal, 1 slow, 2 tied low, 3 stuck high
  logic slow_ack = 1'b0;
  int hi_cnt = 0, lo_cnt = 0, req_hi_a = 0;
  bit req_seen_b = 1'b0;
  logic [31:0] mem_a [4];

  int errors = 0;
  int checks = 0;

  fll_cfg_apb_if #(.TIMEOUT_CYCLES(256)) dut_a (
    .clk_i(clk), .rstn_i(rstn), .psel_i(psel_a), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata_a), .pready_o(pready_a),
    .pslverr_o(slverr_a), .cfg_req_o(req_a), .cfg_wrn_o(wrn_a), .cfg_add_o(add_a),
    .cfg_data_o(data_a), .cfg_ack_i(ack_a), .cfg_r_data_i(rdat_a), .timeout_o(tmo_a));

  fll_cfg_apb_if #(.TIMEOUT_CYCLES(16)) dut_b (
    .clk_i(clk), .rstn_i(rstn), .psel_i(psel_b), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata_b), .pready_o(pready_b),
    .pslverr_o(slverr_b), .cfg_req_o(req_b), .cfg_wrn_o(wrn_b), .cfg_add_o(add_b),
    .cfg_data_o(data_b), .cfg_ack_i(ack_b), .cfg_r_data_i(rdat_b), .timeout_o(tmo_b));

  assign ack_a  = (mode_a == 0) ? req_a : (mode_a == 1) ? slow_ack : (mode_a == 3);
  assign ack_b  = (mode_b == 0) ? req_b : (mode_b == 1) ? 1'b0 : (mode_b == 3);
  assign rdat_a = mem_a[add_a];
  assign rdat_b = 32'hBBBB_0000 | {30'd0, add_b};

  always @(posedge clk) begin
    if (req_a && wrn_a) mem_a[add_a] <= data_a;
    if (req_a) begin
      lo_cnt <= 0;
      if (hi_cnt == 19) slow_ack <= 1'b1;
      hi_cnt <= hi_cnt + 1;
    end else begin
      hi_cnt <= 0;
      if (slow_ack) begin
        if (lo_cnt == 14) slow_ack <= 1'b0;
        lo_cnt <= lo_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (req_a) req_hi_a++;
    if (req_b) req_seen_b = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives setup after edge E0; n = k where pready is high in the cycle after edge Ek.
  task automatic apb(input bit b, input bit wr, input logic [11:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int n);
    @(posedge clk); #1;
    if (b) psel_b = 1'b1; else psel_a = 1'b1;
    penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    n = 1;
    forever begin
      @(negedge clk);
      if (b ? pready_b : pready_a) break;
      if (n > 600) begin
        chk("pready_bound", {31'd0, b ? pready_b : pready_a}, 32'd1);
        break;
      end
      @(posedge clk);
      n++;
    end
    rd = b ? prdata_b : prdata_a;
    er = b ? slverr_b : slverr_a;
    @(posedge clk); #1;
    psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic er;
  int n;

  initial begin
    for (int i = 0; i < 4; i++) mem_a[i] = 32'hDEAD_0000 + 32'(i);
    #1;
    chk("rst_req", {31'd0, req_a}, 32'd0);
    chk("rst_pready", {31'd0, pready_a}, 32'd0);
    chk("rst_prdata", prdata_a, 32'd0);
    chk("rst_data", data_a, 32'd0);
    chk("rst_tmo_b", {31'd0, tmo_b}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // ideal FLL write then read
    apb(0, 1, 12'h004, 32'hA5A5_0001, rd, er, n);
    chk("wr_lat", n, 7);
    chk("wr_err", {31'd0, er}, 32'd0);
    chk("wr_add", {30'd0, add_a}, 32'd1);
    chk("wr_wrn", {31'd0, wrn_a}, 32'd1);
    chk("wr_data", data_a, 32'hA5A5_0001);
    chk("wr_prdata", rd, 32'd0);
    apb(0, 0, 12'h004, 32'h0, rd, er, n);
    chk("rd_lat", n, 7);
    chk("rd_err", {31'd0, er}, 32'd0);
    chk("rd_data", rd, 32'hA5A5_0001);
    chk("rd_wrn", {31'd0, wrn_a}, 32'd0);
    apb(0, 0, 12'h00C, 32'h0, rd, er, n);
    chk("rd3_data", rd, 32'hDEAD_0003);

    // slow FLL: ack 20 cycles after req, dropped 15 after req falls
    mode_a = 1;
    req_hi_a = 0;
    apb(0, 1, 12'h008, 32'h1234_5678, rd, er, n);
    chk("slow_lat", n, 42);
    chk("slow_err", {31'd0, er}, 32'd0);
    chk("slow_req_hi", req_hi_a, 23);
    chk("slow_tmo", {31'd0, tmo_a}, 32'd0);
    mode_a = 0;
    apb(0, 0, 12'h008, 32'h0, rd, er, n);
    chk("slow_readback", rd, 32'h1234_5678);

    // non-responding FLL on dut_b
    apb(1, 0, 12'h008, 32'h0, rd, er, n);
    chk("nr_lat", n, 18);
    chk("nr_err", {31'd0, er}, 32'd1);
    chk("nr_prdata", rd, 32'd0);
    chk("nr_tmo", {31'd0, tmo_b}, 32'd1);
    apb(1, 0, 12'h010, 32'h0, rd, er, n);
    chk("st_val", rd, 32'h1);
    chk("st_lat", n, 1);
    chk("st_err", {31'd0, er}, 32'd0);
    apb(1, 1, 12'h010, 32'h1, rd, er, n);
    chk("st_clr", {31'd0, tmo_b}, 32'd0);

    // illegal address
    req_seen_b = 1'b0;
    apb(1, 0, 12'h020, 32'h0, rd, er, n);
    chk("ill_lat", n, 1);
    chk("ill_err", {31'd0, er}, 32'd1);
    chk("ill_noreq", {31'd0, req_seen_b}, 32'd0);
    chk("ill_prdata", rd, 32'd0);

    // ack stuck high
    mode_b = 3;
    repeat (4) @(posedge clk);
    apb(1, 0, 12'h010, 32'h0, rd, er, n);
    chk("stk_busy", rd, 32'h2);
    apb(1, 1, 12'h000, 32'h55, rd, er, n);
    chk("stk_lat", n, 18);
    chk("stk_err", {31'd0, er}, 32'd1);
    apb(1, 0, 12'h010, 32'h0, rd, er, n);
    chk("stk_status", rd, 32'h3);
    mode_b = 2;

    // reset 2 cycles after cfg_req rises on dut_a
    mode_a = 2;
    @(posedge clk); #1;
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h004; pwdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int i = 0; i < 20 && !req_a; i++) @(negedge clk);
    chk("mid_req_up", {31'd0, req_a}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    chk("mid_req", {31'd0, req_a}, 32'd0);
    chk("mid_wrn", {31'd0, wrn_a}, 32'd0);
    chk("mid_data", data_a, 32'd0);
    chk("mid_pready", {31'd0, pready_a}, 32'd0);
    chk("mid_tmo_b", {31'd0, tmo_b}, 32'd0);
    psel_a = 1'b0; penable = 1'b0;
    mode_a = 0;
    @(posedge clk); #1 rstn = 1'b1;
    apb(0, 1, 12'h004, 32'hA5A5_0001, rd, er, n);
    chk("post_lat", n, 7);
    chk("post_err", {31'd0, er}, 32'd0);
    chk("post_data", data_a, 32'hA5A5_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
